// File: rtl/udp_cmd_rx_decoder.sv
// Decodes 8-byte command datagrams from the UDP receive path into the transmit-side
// configuration registers, with saturating good/bad command counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for the rising edge of app_rx_data_valid
// HDR      | checking bytes 1-3: magic low byte, opcode, address
// DATA     | shifting in bytes 4-7 as DATA[31:0], MSB first
// WAIT_END | discarding bytes until app_rx_data_valid drops
module udp_cmd_rx_decoder #(
  parameter logic [15:0] CMD_PORT       = 16'd8080,
  parameter logic [15:0] DEF_UDP_LENGTH = 16'd2050,
  parameter logic [31:0] DEF_DST_IP     = 32'hC0A8F002,
  parameter logic [15:0] DEF_DST_PORT   = 16'd8080,
  parameter logic [1:0]  DEF_TRI_SPEED  = 2'b10
) (
  input  logic        udp_clk,
  input  logic        rst_n,
  input  logic        app_rx_data_valid,
  input  logic [7:0]  app_rx_data,
  input  logic [15:0] app_rx_data_length,
  input  logic [15:0] app_rx_port_num,
  output logic        cfg_stream_en,
  output logic [1:0]  cfg_tri_speed,
  output logic [15:0] cfg_udp_length,
  output logic [31:0] cfg_dst_ip,
  output logic [15:0] cfg_dst_port,
  output logic        cmd_strobe,
  output logic [15:0] cmd_ok_cnt,
  output logic [15:0] cmd_err_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HDR      = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_WAIT_END = 2'd3;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_CLEAR = 8'h03;

  logic [1:0]  state;
  logic        prev_valid;
  logic        bad;
  logic        commit_pend;
  logic [2:0]  byte_cnt;
  logic [7:0]  opcode;
  logic [7:0]  addr;
  logic [31:0] data_sr;
  logic        start;

  assign start = app_rx_data_valid & ~prev_valid;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge udp_clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      prev_valid     <= 1'b1;  // a datagram in flight at reset release is never started
      bad            <= 1'b0;
      commit_pend    <= 1'b0;
      byte_cnt       <= 3'd0;
      opcode         <= 8'h00;
      addr           <= 8'h00;
      data_sr        <= 32'h0;
      cfg_stream_en  <= 1'b0;
      cfg_tri_speed  <= DEF_TRI_SPEED;
      cfg_udp_length <= DEF_UDP_LENGTH;
      cfg_dst_ip     <= DEF_DST_IP;
      cfg_dst_port   <= DEF_DST_PORT;
      cmd_strobe     <= 1'b0;
      cmd_ok_cnt     <= 16'h0;
      cmd_err_cnt    <= 16'h0;
    end else begin
      prev_valid  <= app_rx_data_valid;
      cmd_strobe  <= 1'b0;
      commit_pend <= 1'b0;

      if (commit_pend) begin
        cmd_strobe <= 1'b1;
        if (opcode == OP_CLEAR) begin
          cmd_ok_cnt  <= 16'h0;
          cmd_err_cnt <= 16'h0;
        end else begin
          cmd_ok_cnt <= sat_inc(cmd_ok_cnt);
          case (addr)
            8'h00: begin
              cfg_stream_en <= data_sr[0];
              cfg_tri_speed <= data_sr[2:1];
            end
            8'h01:   cfg_udp_length <= data_sr[15:0];
            8'h02:   cfg_dst_ip     <= data_sr;
            8'h03:   cfg_dst_port   <= data_sr[15:0];
            default: ;
          endcase
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            byte_cnt <= 3'd1;
            bad      <= (app_rx_port_num != CMD_PORT) ||
                        (app_rx_data_length != 16'd8) ||
                        (app_rx_data != 8'hA5);
            state    <= S_HDR;
          end
        end
        S_HDR: begin
          if (!app_rx_data_valid) begin
            cmd_err_cnt <= sat_inc(cmd_err_cnt);
            state       <= S_IDLE;
          end else begin
            byte_cnt <= byte_cnt + 3'd1;
            case (byte_cnt)
              3'd1: if (app_rx_data != 8'h5A) bad <= 1'b1;
              3'd2: begin
                opcode <= app_rx_data;
                if (app_rx_data != OP_WRITE && app_rx_data != OP_CLEAR) bad <= 1'b1;
              end
              3'd3: begin
                addr  <= app_rx_data;
                if (opcode == OP_WRITE && app_rx_data > 8'h03) bad <= 1'b1;
                state <= S_DATA;
              end
              default: ;
            endcase
          end
        end
        S_DATA: begin
          if (!app_rx_data_valid) begin
            cmd_err_cnt <= sat_inc(cmd_err_cnt);
            state       <= S_IDLE;
          end else begin
            data_sr  <= {data_sr[23:0], app_rx_data};
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd7) begin
              if (bad) cmd_err_cnt <= sat_inc(cmd_err_cnt);
              else     commit_pend <= 1'b1;
              state <= S_WAIT_END;
            end
          end
        end
        default: begin
          if (!app_rx_data_valid) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_cmd_rx_decoder.sv
// Directed bench for udp_cmd_rx_decoder: a datagram-level model predicts every output
// each cycle, and literal checks pin the model at the key points.
module tb_udp_cmd_rx_decoder;

  localparam logic [15:0] CMD_PORT = 16'd8080;

  logic        udp_clk = 1'b0;
  logic        rst_n;
  logic        app_rx_data_valid;
  logic [7:0]  app_rx_data;
  logic [15:0] app_rx_data_length;
  logic [15:0] app_rx_port_num;
  logic        cfg_stream_en;
  logic [1:0]  cfg_tri_speed;
  logic [15:0] cfg_udp_length;
  logic [31:0] cfg_dst_ip;
  logic [15:0] cfg_dst_port;
  logic        cmd_strobe;
  logic [15:0] cmd_ok_cnt;
  logic [15:0] cmd_err_cnt;

  udp_cmd_rx_decoder dut (
    .udp_clk(udp_clk), .rst_n(rst_n),
    .app_rx_data_valid(app_rx_data_valid), .app_rx_data(app_rx_data),
    .app_rx_data_length(app_rx_data_length), .app_rx_port_num(app_rx_port_num),
    .cfg_stream_en(cfg_stream_en), .cfg_tri_speed(cfg_tri_speed),
    .cfg_udp_length(cfg_udp_length), .cfg_dst_ip(cfg_dst_ip),
    .cfg_dst_port(cfg_dst_port), .cmd_strobe(cmd_strobe),
    .cmd_ok_cnt(cmd_ok_cnt), .cmd_err_cnt(cmd_err_cnt)
  );

  always #5 udp_clk = ~udp_clk;

  int total = 0;
  int bad = 0;
  int strobe_cycles = 0;
  logic chk_on = 1'b0;

  // expected register image
  logic        exp_en;
  logic [1:0]  exp_tri;
  logic [15:0] exp_len;
  logic [31:0] exp_ip;
  logic [15:0] exp_port;
  logic        exp_strobe;
  logic [15:0] exp_ok;
  logic [15:0] exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  task automatic model_reset();
    exp_en = 1'b0; exp_tri = 2'b10; exp_len = 16'd2050;
    exp_ip = 32'hC0A8F002; exp_port = 16'd8080;
    exp_strobe = 1'b0; exp_ok = 16'h0; exp_err = 16'h0;
  endtask

  task automatic apply_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] d);
    exp_strobe = 1'b1;
    if (op == 8'h03) begin
      exp_ok = 16'h0; exp_err = 16'h0;
    end else begin
      exp_ok = sat(exp_ok);
      if (addr == 8'h00) begin exp_en = d[0]; exp_tri = d[2:1]; end
      if (addr == 8'h01) exp_len  = d[15:0];
      if (addr == 8'h02) exp_ip   = d;
      if (addr == 8'h03) exp_port = d[15:0];
    end
  endtask

  always @(negedge udp_clk) begin
    if (chk_on) begin
      check("stream_en",  {31'b0, cfg_stream_en}, {31'b0, exp_en});
      check("tri_speed",  {30'b0, cfg_tri_speed}, {30'b0, exp_tri});
      check("udp_length", {16'b0, cfg_udp_length}, {16'b0, exp_len});
      check("dst_ip",     cfg_dst_ip, exp_ip);
      check("dst_port",   {16'b0, cfg_dst_port}, {16'b0, exp_port});
      check("cmd_strobe", {31'b0, cmd_strobe}, {31'b0, exp_strobe});
      check("ok_cnt",     {16'b0, cmd_ok_cnt}, {16'b0, exp_ok});
      check("err_cnt",    {16'b0, cmd_err_cnt}, {16'b0, exp_err});
      if (cmd_strobe === 1'b1) strobe_cycles++;
    end
  end

  // One datagram of nb bytes in a single valid run; edge e accepts byte e.
  task automatic send(input logic [15:0] magic, input logic [7:0] op, input logic [7:0] addr,
                      input logic [31:0] d, input int nb, input logic [15:0] len,
                      input logic [15:0] port);
    logic [7:0] b [16];
    logic good;
    int commit_edge, err_edge;
    b[0] = magic[15:8]; b[1] = magic[7:0]; b[2] = op; b[3] = addr;
    b[4] = d[31:24]; b[5] = d[23:16]; b[6] = d[15:8]; b[7] = d[7:0];
    for (int i = 8; i < 16; i++) b[i] = 8'hE0 | 8'(i);
    good = (nb >= 8) && (port == CMD_PORT) && (len == 16'd8) && (magic == 16'hA55A) &&
           ((op == 8'h03) || (op == 8'h01 && addr <= 8'h03));
    commit_edge = good ? 8 : -1;
    err_edge    = good ? -1 : ((nb >= 8) ? 7 : nb);
    @(posedge udp_clk); #1;
    app_rx_data_valid = 1'b1; app_rx_data = b[0];
    app_rx_data_length = len; app_rx_port_num = port;
    for (int e = 0; e <= nb + 1; e++) begin
      @(posedge udp_clk); #1;
      exp_strobe = 1'b0;
      if (e == commit_edge) apply_cmd(op, addr, d);
      if (e == err_edge) exp_err = sat(exp_err);
      if (e + 1 < nb) app_rx_data = b[e+1];
      else app_rx_data_valid = 1'b0;
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] d);
    send(16'hA55A, 8'h01, addr, d, 8, 16'd8, CMD_PORT);
  endtask

  task automatic do_reset();
    @(posedge udp_clk); #1; rst_n = 1'b0;
    @(posedge udp_clk); #1; model_reset(); rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge udp_clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; app_rx_data_valid = 1'b0; app_rx_data = 8'h00;
    app_rx_data_length = 16'd0; app_rx_port_num = 16'd0;
    model_reset();
    @(posedge udp_clk); #1;
    @(posedge udp_clk); #1;
    chk_on = 1'b1; rst_n = 1'b1;
    check("lit_rst_len", {16'b0, cfg_udp_length}, 32'd2050);
    check("lit_rst_ip", cfg_dst_ip, 32'hC0A8F002);
    check("lit_rst_ok", {16'b0, cmd_ok_cnt}, 32'd0);

    // first write
    wr(8'h01, 32'h0000_0402);
    idle(2);
    check("lit_len_402", {16'b0, cfg_udp_length}, 32'h0402);
    check("lit_ok_1", {16'b0, cmd_ok_cnt}, 32'd1);
    check("lit_err_0", {16'b0, cmd_err_cnt}, 32'd0);
    check("lit_strobe_1", strobe_cycles, 1);

    do_reset();
    wr(8'h00, 32'h0000_0005);
    wr(8'h02, 32'hC0A8_0A0A);
    idle(1);
    check("lit_en", {31'b0, cfg_stream_en}, 32'd1);
    check("lit_tri", {30'b0, cfg_tri_speed}, 32'd2);
    check("lit_ip", cfg_dst_ip, 32'hC0A8_0A0A);
    check("lit_ok_2", {16'b0, cmd_ok_cnt}, 32'd2);

    // rejected datagrams
    send(16'hA55B, 8'h01, 8'h01, 32'h1111, 8, 16'd8, CMD_PORT);
    send(16'hA55A, 8'h01, 8'h01, 32'h2222, 8, 16'd8, 16'd8081);
    send(16'hA55A, 8'h01, 8'h01, 32'h3333, 9, 16'd9, CMD_PORT);
    send(16'hA55A, 8'h01, 8'h01, 32'h4444, 5, 16'd8, CMD_PORT);
    idle(1);
    check("lit_err_4", {16'b0, cmd_err_cnt}, 32'd4);
    check("lit_len_kept", {16'b0, cfg_udp_length}, 32'd2050);
    check("lit_strobe_3", strobe_cycles, 3);
    send(16'hA55A, 8'h02, 8'h01, 32'h5555, 8, 16'd8, CMD_PORT);
    send(16'hA55A, 8'h01, 8'h04, 32'h6666, 8, 16'd8, CMD_PORT);
    send(16'hA55A, 8'h01, 8'h01, 32'h7777, 1, 16'd8, CMD_PORT);
    send(16'h5A5A, 8'h05, 8'h09, 32'h8888, 8, 16'd8, 16'd1);

    // good write with trailing bytes, then a normal one
    send(16'hA55A, 8'h01, 8'h03, 32'h0000_1F91, 12, 16'd8, CMD_PORT);
    wr(8'h01, 32'h0000_0800);
    idle(1);
    check("lit_port", {16'b0, cfg_dst_port}, 32'h1F91);
    check("lit_len_800", {16'b0, cfg_udp_length}, 32'h0800);
    check("lit_err_8", {16'b0, cmd_err_cnt}, 32'd8);

    // clear opcode
    do_reset();
    wr(8'h03, 32'h0000_1234);
    send(16'hA55A, 8'h01, 8'h07, 32'h0, 8, 16'd8, CMD_PORT);
    wr(8'h00, 32'h0000_0003);
    send(16'hA55A, 8'h01, 8'h01, 32'h0, 3, 16'd8, CMD_PORT);
    wr(8'h01, 32'h0000_0100);
    idle(1);
    check("lit_pre_ok_3", {16'b0, cmd_ok_cnt}, 32'd3);
    check("lit_pre_err_2", {16'b0, cmd_err_cnt}, 32'd2);
    send(16'hA55A, 8'h03, 8'h77, 32'hFFFF_FFFF, 8, 16'd8, CMD_PORT);
    idle(1);
    check("lit_clr_ok", {16'b0, cmd_ok_cnt}, 32'd0);
    check("lit_clr_err", {16'b0, cmd_err_cnt}, 32'd0);
    check("lit_clr_len", {16'b0, cfg_udp_length}, 32'h0100);

    // saturation
    force dut.cmd_ok_cnt = 16'hFFFE;
    force dut.cmd_err_cnt = 16'hFFFE;
    exp_ok = 16'hFFFE; exp_err = 16'hFFFE;
    @(posedge udp_clk); #1;
    release dut.cmd_ok_cnt;
    release dut.cmd_err_cnt;
    idle(1);
    wr(8'h03, 32'h0000_0001);
    wr(8'h03, 32'h0000_0002);
    send(16'hA55A, 8'h09, 8'h00, 32'h0, 8, 16'd8, CMD_PORT);
    send(16'hA55A, 8'h01, 8'h00, 32'h0, 2, 16'd8, CMD_PORT);
    idle(1);
    check("lit_ok_sat", {16'b0, cmd_ok_cnt}, 32'hFFFF);
    check("lit_err_sat", {16'b0, cmd_err_cnt}, 32'hFFFF);

    // reset in the middle of a write, released with valid still high
    wr(8'h01, 32'h0000_0999);
    app_rx_data_length = 16'd8; app_rx_port_num = CMD_PORT;
    begin
      logic [7:0] mb [10];
      mb[0] = 8'hA5; mb[1] = 8'h5A; mb[2] = 8'h01; mb[3] = 8'h01; mb[4] = 8'h00;
      mb[5] = 8'h00; mb[6] = 8'h11; mb[7] = 8'h11; mb[8] = 8'hA5; mb[9] = 8'h5A;
      for (int i = 0; i <= 5; i++) begin
        @(posedge udp_clk); #1; exp_strobe = 1'b0;
        app_rx_data_valid = 1'b1; app_rx_data = mb[i];
      end
      @(posedge udp_clk); #1; rst_n = 1'b0; app_rx_data = mb[6];
      @(posedge udp_clk); #1; model_reset(); rst_n = 1'b1; app_rx_data = mb[7];
      for (int i = 8; i < 10; i++) begin
        @(posedge udp_clk); #1; app_rx_data = mb[i];
      end
      @(posedge udp_clk); #1; app_rx_data_valid = 1'b0;
    end
    idle(3);
    check("lit_mid_rst_len", {16'b0, cfg_udp_length}, 32'd2050);
    check("lit_mid_rst_ok", {16'b0, cmd_ok_cnt}, 32'd0);
    check("lit_mid_rst_err", {16'b0, cmd_err_cnt}, 32'd0);
    wr(8'h01, 32'h0000_0123);
    idle(1);
    check("lit_after_rst_len", {16'b0, cfg_udp_length}, 32'h0123);
    check("lit_after_rst_ok", {16'b0, cmd_ok_cnt}, 32'd1);

    idle(2);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
